// File: rtl/rr_arbiter_grant.sv
// Round-robin wormhole grant FSM for a 4-port output channel (IDLE/LOCKED/RELEASE).
// Optional forced release of a stalled owner when RR_GRANT_TIMEOUT_EN is defined.
module rr_arbiter_grant #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req_i,
   input  logic [3:0] tail_i,
   input  logic [3:0] priority_order_i,
   input  logic       out_ready_i,
   output logic [3:0] grant_o,
   output logic       fire_o,
   output logic       change_order_o,
   output logic       timeout_o
);

   typedef enum logic [1:0] {IDLE, LOCKED, RELEASE} state_e;

   localparam logic [3:0] TO_LIMIT = 4'(TIMEOUT_CYCLES);

   state_e     state_q, state_d;
   logic [3:0] grant_q, grant_d;
   logic       change_q, change_d;
   logic [1:0] p_idx;
   logic [1:0] scan_idx;
   logic       found;
   logic [3:0] sel;
   logic       tail_hit;
   logic       to_hit;

   // Start index is the lowest set bit of the priority vector, 0 when empty.
   always_comb begin
      p_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (priority_order_i[i]) p_idx = 2'(i);
      end
   end

   always_comb begin
      sel      = 4'b0000;
      found    = 1'b0;
      scan_idx = 2'd0;
      for (int k = 0; k < 4; k++) begin
         scan_idx = p_idx + 2'(k);
         if (!found && req_i[scan_idx]) begin
            sel[scan_idx] = 1'b1;
            found         = 1'b1;
         end
      end
   end

   assign fire_o   = (state_q == LOCKED) && (|(grant_q & req_i)) && out_ready_i;
   assign tail_hit = |(grant_q & tail_i);

`ifdef RR_GRANT_TIMEOUT_EN
   logic [3:0] cnt_q, cnt_d;
   logic       timeout_q;

   assign to_hit = (state_q == LOCKED) && !fire_o && ((cnt_q + 4'd1) == TO_LIMIT);

   always_comb begin
      cnt_d = 4'd0;
      if ((state_q == LOCKED) && !fire_o && !to_hit) cnt_d = cnt_q + 4'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q     <= 4'd0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= (state_q == LOCKED) && !(fire_o && tail_hit) && to_hit;
      end
   end

   assign timeout_o = timeout_q;
`else
   assign to_hit    = 1'b0;
   // Legal TIMEOUT_CYCLES is 1..15, so this folds to a constant 0.
   assign timeout_o = (TO_LIMIT == 4'd0);
`endif

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      change_d = 1'b0;
      case (state_q)
         IDLE: begin
            grant_d = 4'b0000;
            if (|req_i) begin
               grant_d = sel;
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            if ((fire_o && tail_hit) || to_hit) begin
               grant_d  = 4'b0000;
               state_d  = RELEASE;
               change_d = 1'b1;
            end
         end
         RELEASE: begin
            grant_d = 4'b0000;
            state_d = IDLE;
         end
         default: begin
            grant_d = 4'b0000;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         grant_q  <= 4'b0000;
         change_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         change_q <= change_d;
      end
   end

   assign grant_o        = grant_q;
   assign change_order_o = change_q;

endmodule

// File: tb/tb_rr_arbiter_grant.sv
// Directed-vector bench for rr_arbiter_grant; expected values hand-derived per step.
module tb_rr_arbiter_grant;

   logic       clk;
   logic       reset;
   logic [3:0] req_i;
   logic [3:0] tail_i;
   logic [3:0] priority_order_i;
   logic       out_ready_i;
   logic [3:0] grant_o;
   logic       fire_o;
   logic       change_order_o;
   logic       timeout_o;

   int vectors;
   int miscompares;

   rr_arbiter_grant dut (
      .clk              (clk),
      .reset            (reset),
      .req_i            (req_i),
      .tail_i           (tail_i),
      .priority_order_i (priority_order_i),
      .out_ready_i      (out_ready_i),
      .grant_o          (grant_o),
      .fire_o           (fire_o),
      .change_order_o   (change_order_o),
      .timeout_o        (timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      logic [3:0] exp_g;
      vectors          = 0;
      miscompares      = 0;
      reset            = 1'b0;
      req_i            = 4'b1111;
      tail_i           = 4'b0000;
      priority_order_i = 4'b0001;
      out_ready_i      = 1'b1;

      // reset state, requests pending while reset held
      #3;
      chk("rst_grant", grant_o, 4'b0000);
      chk("rst_fire", {3'b0, fire_o}, 4'b0);
      chk("rst_change", {3'b0, change_order_o}, 4'b0);
      chk("rst_timeout", {3'b0, timeout_o}, 4'b0);
      tick();
      tick();
      chk("rst_hold_grant", grant_o, 4'b0000);

      // idle with no requests
      reset = 1'b1;
      req_i = 4'b0000;
      tick();
      chk("idle_grant", grant_o, 4'b0000);
      chk("idle_change", {3'b0, change_order_o}, 4'b0);

      // single-flit packet from ports 1/2, priority at port 0
      req_i  = 4'b0110;
      tail_i = 4'b0110;
      #1;
      chk("p29_fire_idle", {3'b0, fire_o}, 4'b0);
      tick();
      chk("p29_grant", grant_o, 4'b0010);
      chk("p29_fire", {3'b0, fire_o}, 4'b1);
      tick();
      chk("p29_rel_grant", grant_o, 4'b0000);
      chk("p29_rel_change", {3'b0, change_order_o}, 4'b1);
      chk("p29_rel_fire", {3'b0, fire_o}, 4'b0);
      req_i = 4'b0000;
      tick();
      chk("p29_idle_change", {3'b0, change_order_o}, 4'b0);
      chk("p29_idle_grant", grant_o, 4'b0000);

      // wrap from port 3 to port 0
      priority_order_i = 4'b1000;
      req_i            = 4'b0101;
      tail_i           = 4'b0000;
      tick();
      chk("wrap_grant", grant_o, 4'b0001);
      tail_i = 4'b0001;
      #1;
      chk("wrap_fire", {3'b0, fire_o}, 4'b1);
      tick();
      chk("wrap_rel_change", {3'b0, change_order_o}, 4'b1);
      req_i = 4'b0000;
      tick();

      // multi-hot priority uses lowest set bit (port 2), then reset mid-packet
      priority_order_i = 4'b1100;
      req_i            = 4'b1011;
      tail_i           = 4'b0000;
      tick();
      chk("multihot_grant", grant_o, 4'b1000);
      reset = 1'b0;
      #1;
      chk("midrst_grant", grant_o, 4'b0000);
      chk("midrst_change", {3'b0, change_order_o}, 4'b0);
      chk("midrst_fire", {3'b0, fire_o}, 4'b0);
      tick();
      chk("midrst_hold_change", {3'b0, change_order_o}, 4'b0);
      reset = 1'b1;
      req_i = 4'b0000;
      tick();
      chk("midrst_after_grant", grant_o, 4'b0000);
      chk("midrst_after_change", {3'b0, change_order_o}, 4'b0);

      // zero priority vector starts the scan at port 0
      priority_order_i = 4'b0000;
      req_i            = 4'b1010;
      tail_i           = 4'b0010;
      tick();
      chk("zeroprio_grant", grant_o, 4'b0010);
      tick();
      req_i = 4'b0000;
      tick();

      // 3-flit packet on port 2 with a 2-cycle stall, all ports requesting
      priority_order_i = 4'b0100;
      req_i            = 4'b1111;
      tail_i           = 4'b0000;
      tick();
      chk("p31_grant", grant_o, 4'b0100);
      chk("p31_fire1", {3'b0, fire_o}, 4'b1);
      tick();
      out_ready_i = 1'b0;
      #1;
      chk("p31_stall1_fire", {3'b0, fire_o}, 4'b0);
      chk("p31_stall1_grant", grant_o, 4'b0100);
      tick();
      chk("p31_stall2_fire", {3'b0, fire_o}, 4'b0);
      chk("p31_stall2_grant", grant_o, 4'b0100);
      tick();
      out_ready_i = 1'b1;
      #1;
      chk("p31_fire2", {3'b0, fire_o}, 4'b1);
      chk("p31_mid_change", {3'b0, change_order_o}, 4'b0);
      tick();
      tail_i = 4'b0100;
      #1;
      chk("p31_fire3", {3'b0, fire_o}, 4'b1);
      chk("p31_grant3", grant_o, 4'b0100);
      tick();
      chk("p31_rel_grant", grant_o, 4'b0000);
      chk("p31_rel_change", {3'b0, change_order_o}, 4'b1);
      tick();
      chk("p31_idle_change", {3'b0, change_order_o}, 4'b0);
      chk("p31_idle_grant", grant_o, 4'b0000);

      // owner drops req while locked: grant held, no transfer
      tick();
      chk("drop_grant", grant_o, 4'b0100);
      req_i  = 4'b1011;
      tail_i = 4'b0000;
      #1;
      chk("drop_fire", {3'b0, fire_o}, 4'b0);
`ifndef RR_GRANT_TIMEOUT_EN
      for (int c = 0; c < 20; c++) tick();
      chk("drop_long_grant", grant_o, 4'b0100);
      chk("drop_long_timeout", {3'b0, timeout_o}, 4'b0);
`else
      for (int c = 0; c < 14; c++) tick();
      chk("to_before_grant", grant_o, 4'b0100);
      tick();
      chk("to_grant", grant_o, 4'b0000);
      chk("to_pulse", {3'b0, timeout_o}, 4'b1);
      chk("to_change", {3'b0, change_order_o}, 4'b1);
      tick();
      chk("to_clear", {3'b0, timeout_o}, 4'b0);
      req_i = 4'b0000;
      tick();
      tick();
      req_i = 4'b0100;
      tick();
`endif
      req_i  = 4'b0100;
      tail_i = 4'b0100;
      #1;
      chk("drop_resume_fire", {3'b0, fire_o}, 4'b1);
      tick();
      chk("drop_rel_change", {3'b0, change_order_o}, 4'b1);
      req_i = 4'b0000;
      tick();

      // closed loop with rotating priority: each port once per 4 packets
      exp_g            = 4'b0001;
      priority_order_i = 4'b0001;
      req_i            = 4'b1111;
      tail_i           = 4'b1111;
      for (int n = 0; n < 8; n++) begin
         tick();
         chk("rot_grant", grant_o, exp_g);
         chk("rot_fire", {3'b0, fire_o}, 4'b1);
         tick();
         chk("rot_change", {3'b0, change_order_o}, 4'b1);
         exp_g            = {exp_g[2:0], exp_g[3]};
         priority_order_i = exp_g;
         tick();
         chk("rot_idle_grant", grant_o, 4'b0000);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_grant.md
RR_ARBITER_GRANT -- requirements
Module: rr_arbiter_grant

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 15, consecutive stalled LOCKED cycles before forced release (used only under RR_GRANT_TIMEOUT_EN; legal 1..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req_i  input  4  per-port request; bit n = port n has a flit.
REQ-005 SHALL have port: tail_i  input  4  per-port tail marker; meaningful only with req_i[n].
REQ-006 SHALL have port: priority_order_i  input  4  one-hot highest-priority port, driven by rr_register_0001 priority_order_o.
REQ-007 SHALL have port: out_ready_i  input  1  downstream output channel can accept a flit this cycle.
REQ-008 SHALL have port: grant_o  output  4  registered one-hot grant, all-zero when no owner.
REQ-009 SHALL have port: fire_o  output  1  combinational flit transfer strobe.
REQ-010 SHALL have port: change_order_o  output  1  registered one-cycle pulse to rr_register_0001 change_order_i.
REQ-011 SHALL have port: timeout_o  output  1  registered one-cycle forced-release pulse.

Function
REQ-012 SHALL implement FSM states IDLE, LOCKED, RELEASE.
REQ-013 In IDLE with req_i != 0: select first set req bit scanning upward from index p of priority_order_i (p, p+1, ... wrapping 3->0); load grant_o at next edge; go LOCKED.
REQ-014 Arbitration latency: exactly 1 cycle from req visible in IDLE to grant_o valid.
REQ-015 priority_order_i zero or multi-hot: p = index of lowest set bit; p = 0 when zero.
REQ-016 In IDLE with req_i == 0: stay IDLE, grant_o = 0.
REQ-017 fire_o = LOCKED && |(grant_o & req_i) && out_ready_i.
REQ-018 LOCKED, fire_o with tail_i of granted port = 1: clear grant_o at next edge; go RELEASE.
REQ-019 LOCKED, requester deasserts req or out_ready_i = 0: hold grant (wormhole lock), no transfer.
REQ-020 RELEASE lasts exactly 1 cycle: change_order_o = 1, grant_o = 0, fire_o = 0, no arbitration; then IDLE. Guarantees rotated priority is sampled by the next IDLE.
REQ-021 change_order_o SHALL be 1 only during RELEASE; never two consecutive cycles.
REQ-022 Requests from other ports during LOCKED/RELEASE SHALL be ignored until IDLE.
REQ-023 Single-flit packet (req and tail together): sequence IDLE -> LOCKED (fire) -> RELEASE -> IDLE, minimum 3 cycles per packet.

Reset
REQ-024 reset low SHALL asynchronously force: state IDLE, grant_o = 0, change_order_o = 0, timeout_o = 0, timeout counter = 0.
REQ-025 Reset asserted mid-packet SHALL drop ownership with no change_order_o pulse; fire_o = 0 while reset low.
REQ-026 First arbitration after reset deassertion SHALL occur no earlier than the first edge with reset high.

Configuration
REQ-027 Macro RR_GRANT_TIMEOUT_EN defined: 4-bit counter increments each LOCKED cycle without fire_o, clears on fire_o or state exit; on reaching TIMEOUT_CYCLES, next edge clears grant_o, enters RELEASE, timeout_o = 1 for that RELEASE cycle.
REQ-028 Macro not defined: no counter; timeout_o tied 0; LOCKED exits only per REQ-018 or reset.

Verification
REQ-029 priority 0001, req 0110 tail 0110, ready 1 -> grant 0010 next cycle, fire 1, RELEASE with change_order 1, then IDLE.
REQ-030 priority 1000, req 0101 -> grant 0001 (wrap from 3 to 0).
REQ-031 Port 2 granted, 3-flit packet, ready 0 for 2 cycles mid-packet, req 1111 throughout -> grant stays 0100, fire count 3, single change_order pulse after tail.
REQ-032 Reset low during LOCKED with grant 1000 -> grant 0000 immediately (no edge), change_order 0, IDLE after release.
REQ-033 With RR_GRANT_TIMEOUT_EN, TIMEOUT_CYCLES 4, granted port drops req for 4 cycles -> grant cleared, timeout_o and change_order_o 1 same cycle; without macro grant held indefinitely.
REQ-034 Loop with rr_register_0001, req 1111, single-flit packets -> grants visit each port once per 4 packets, no port repeated before all served.
